// File: rtl/sobel_stream_param.sv
// Streaming 3x3 Sobel edge filter over a raster pixel stream. Output is delayed
// by one row plus one pixel; the last COLS+1 outputs are drained by a flush phase.
//
// state | meaning
// IDLE  | waiting for an SOF transfer; non-SOF transfers are dropped
// RUN   | accepting frame pixels, one output per pixel once the window is primed
// FLUSH | input stalled, emitting the remaining COLS+1 outputs
module sobel_stream_param #(
   parameter int DATA_W = 8,
   parameter int COLS   = 1280,
   parameter int ROWS   = 953
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_pixel,
   input  logic              in_sof,
   input  logic [1:0]        mode,
   input  logic [DATA_W+3:0] thresh,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_pixel,
   output logic              out_sof,
   output logic              out_eol,
   output logic              out_eof,
   output logic              busy
);
   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS + 2);
   localparam int FW = $clog2(COLS + 1);
   localparam int SW = DATA_W + 3;
   localparam int AW = DATA_W + 4;
   localparam logic [CW-1:0]     LAST_COL = CW'(COLS - 1);
   localparam logic [RW-1:0]     LAST_ROW = RW'(ROWS - 1);
   localparam logic [DATA_W-1:0] PIX_MAX  = '1;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
   state_t state_q, state_d;

   logic [CW-1:0]     col_q, cur_col, nxt_col, out_col;
   logic [RW-1:0]     row_q, cur_row, nxt_row, out_row;
   logic [FW-1:0]     flush_cnt_q;
   logic [1:0]        mode_q;
   logic [AW-1:0]     thresh_q;
   logic              xfer, sof_go, run_adv, flush_adv, advance, last_pix, emit, border;
   logic [DATA_W-1:0] pix_new, mid_rd, top_rd;
   logic [DATA_W-1:0] lb_mid [COLS];
   logic [DATA_W-1:0] lb_top [COLS];
   logic [DATA_W-1:0] w_top [2];
   logic [DATA_W-1:0] w_mid [2];
   logic [DATA_W-1:0] w_bot [2];

   logic [DATA_W+1:0]   gx_pos, gx_neg, gy_pos, gy_neg;
   logic signed [SW-1:0] gx, gy;
   logic [SW-1:0]       ax, ay;
   logic [AW-1:0]       rx, ry, sum_abs, sum_rect, max_abs, comb;
   logic [DATA_W-1:0]   mag;

   assign in_ready  = (state_q != FLUSH);
   assign busy      = (state_q != IDLE);
   assign xfer      = in_valid && in_ready;
   assign sof_go    = xfer && in_sof;
   assign run_adv   = xfer && !in_sof && (state_q == RUN);
   assign flush_adv = (state_q == FLUSH);
   assign advance   = sof_go || run_adv || flush_adv;

   // An SOF pixel is always stream position (0,0), even when it aborts a frame.
   assign cur_col  = sof_go ? '0 : col_q;
   assign cur_row  = sof_go ? '0 : row_q;
   assign last_pix = run_adv && (cur_row == LAST_ROW) && (cur_col == LAST_COL);
   assign nxt_col  = (cur_col == LAST_COL) ? '0 : cur_col + CW'(1);
   assign nxt_row  = (cur_col == LAST_COL) ? cur_row + RW'(1) : cur_row;

   // The window centre trails the current position by COLS+1.
   assign emit    = advance && ((cur_row > RW'(1)) || ((cur_row == RW'(1)) && (cur_col != '0)));
   assign out_col = (cur_col == '0) ? LAST_COL : cur_col - CW'(1);
   assign out_row = (cur_col == '0) ? cur_row - RW'(2) : cur_row - RW'(1);
   assign border  = (out_row == '0) || (out_row == LAST_ROW) ||
                    (out_col == '0) || (out_col == LAST_COL);

   assign pix_new = flush_adv ? '0 : in_pixel;
   assign mid_rd  = lb_mid[cur_col];
   assign top_rd  = lb_top[cur_col];

   always_comb begin
      gx_pos   = {2'b00, w_bot[0]} + {1'b0, w_bot[1], 1'b0} + {2'b00, pix_new};
      gx_neg   = {2'b00, w_top[0]} + {1'b0, w_top[1], 1'b0} + {2'b00, top_rd};
      gy_pos   = {2'b00, top_rd}   + {1'b0, mid_rd, 1'b0}   + {2'b00, pix_new};
      gy_neg   = {2'b00, w_top[0]} + {1'b0, w_mid[0], 1'b0} + {2'b00, w_bot[0]};
      gx       = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
      gy       = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
      ax       = gx[SW-1] ? $unsigned(-gx) : $unsigned(gx);
      ay       = gy[SW-1] ? $unsigned(-gy) : $unsigned(gy);
      rx       = gx[SW-1] ? '0 : {1'b0, $unsigned(gx)};
      ry       = gy[SW-1] ? '0 : {1'b0, $unsigned(gy)};
      sum_abs  = {1'b0, ax} + {1'b0, ay};
      sum_rect = rx + ry;
      max_abs  = (ax > ay) ? {1'b0, ax} : {1'b0, ay};
      case (mode_q)
         2'd0:    comb = sum_rect;
         2'd1:    comb = sum_abs;
         default: comb = max_abs;
      endcase
      mag = (comb[AW-1:DATA_W] != '0) ? PIX_MAX : comb[DATA_W-1:0];
      if (mode_q == 2'd3) mag = (sum_abs >= thresh_q) ? PIX_MAX : '0;
      if (border) mag = '0;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (sof_go) state_d = RUN;
         RUN:     if (last_pix) state_d = FLUSH;
         FLUSH:   if (flush_cnt_q == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         col_q       <= '0;
         row_q       <= '0;
         flush_cnt_q <= '0;
         mode_q      <= '0;
         thresh_q    <= '0;
         out_valid   <= 1'b0;
         out_pixel   <= '0;
         out_sof     <= 1'b0;
         out_eol     <= 1'b0;
         out_eof     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (advance) begin
            col_q <= nxt_col;
            row_q <= nxt_row;
         end
         if (last_pix)
            flush_cnt_q <= FW'(COLS);
         else if (flush_adv && (flush_cnt_q != '0))
            flush_cnt_q <= flush_cnt_q - FW'(1);
         if (sof_go) begin
            mode_q   <= mode;
            thresh_q <= thresh;
         end
         out_valid <= emit;
         out_sof   <= emit && (out_row == '0) && (out_col == '0);
         out_eol   <= emit && (out_col == LAST_COL);
         out_eof   <= emit && (out_row == LAST_ROW) && (out_col == LAST_COL);
         if (emit) out_pixel <= mag;
      end
   end

   // Line buffers and window hold pixel data only; no reset required.
   always_ff @(posedge clk) begin
      if (advance) begin
         lb_mid[cur_col] <= pix_new;
         lb_top[cur_col] <= mid_rd;
         w_top[0]        <= w_top[1];
         w_top[1]        <= top_rd;
         w_mid[0]        <= w_mid[1];
         w_mid[1]        <= mid_rd;
         w_bot[0]        <= w_bot[1];
         w_bot[1]        <= pix_new;
      end
   end
endmodule

// File: tb/tb_sobel_stream_param.sv
// Scoreboard bench for sobel_stream_param on a 4x4 frame: a behavioural Sobel
// model pushes expected outputs, the monitor pops them as out_valid arrives.
module tb_sobel_stream_param;
   localparam int DATA_W = 8;
   localparam int COLS   = 4;
   localparam int ROWS   = 4;
   localparam int NPIX   = ROWS * COLS;
   localparam int PMAX   = (1 << DATA_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_pixel = '0;
   logic              in_sof = 1'b0;
   logic [1:0]        mode = 2'd0;
   logic [DATA_W+3:0] thresh = '0;
   logic              out_valid;
   logic [DATA_W-1:0] out_pixel;
   logic              out_sof, out_eol, out_eof, busy;

   sobel_stream_param #(.DATA_W(DATA_W), .COLS(COLS), .ROWS(ROWS)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_pixel(in_pixel), .in_sof(in_sof), .mode(mode), .thresh(thresh),
      .out_valid(out_valid), .out_pixel(out_pixel), .out_sof(out_sof),
      .out_eol(out_eol), .out_eof(out_eof), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int pix;
      int flags;
   } exp_t;

   exp_t exp_q[$];
   int   img [ROWS][COLS];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_out   = 0;

   task automatic tb_check(input string tag, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic exp_t golden(input int n, input int md, input int th);
      int r = n / COLS;
      int c = n % COLS;
      int gx, gy, ax, ay, v;
      exp_t e;
      e.flags = ((n == 0) ? 4 : 0) + ((c == COLS - 1) ? 2 : 0) + ((n == NPIX - 1) ? 1 : 0);
      e.pix = 0;
      if (r > 0 && r < ROWS - 1 && c > 0 && c < COLS - 1) begin
         gx = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
            - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
         gy = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
            - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
         ax = (gx < 0) ? -gx : gx;
         ay = (gy < 0) ? -gy : gy;
         case (md)
            0:       v = ((gx > 0) ? gx : 0) + ((gy > 0) ? gy : 0);
            1:       v = ax + ay;
            2:       v = (ax > ay) ? ax : ay;
            default: v = (ax + ay >= th) ? PMAX : 0;
         endcase
         e.pix = (v > PMAX) ? PMAX : v;
      end
      return e;
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (out_valid) begin
         n_out++;
         if (exp_q.size() == 0) begin
            tb_check("unexpected_out", 1, 0);
         end else begin
            e = exp_q.pop_front();
            tb_check("out_pixel", int'(out_pixel), e.pix);
            tb_check("out_flags", int'({out_sof, out_eol, out_eof}), e.flags);
         end
      end
   end

   task automatic send_pixel(input int pix, input bit sof, input bit gaps);
      int guard = 0;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
         end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_pixel = DATA_W'(pix);
      in_sof   = sof;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) tb_check("ready_timeout", 0, 1);
      @(posedge clk);
   endtask

   task automatic run_frame(input int md, input int th, input bit gaps, input bit toggle);
      int lo = 0;
      int start;
      mode   = 2'(md);
      thresh = 12'(th);
      start  = n_out;
      for (int n = 0; n < NPIX; n++) exp_q.push_back(golden(n, md, th));
      for (int n = 0; n < NPIX; n++) begin
         if (toggle && n == 8) begin
            mode   = mode ^ 2'd1;
            thresh = thresh + 12'd37;
         end
         send_pixel(img[n / COLS][n % COLS], n == 0, gaps);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      while (!in_ready && lo < 50) begin
         lo++;
         @(negedge clk);
      end
      tb_check("flush_ready_low", lo, COLS + 1);
      repeat (3) @(negedge clk);
      tb_check("queue_drained", exp_q.size(), 0);
      tb_check("frame_outputs", n_out - start, NPIX);
      tb_check("busy_after", int'(busy), 0);
   endtask

   task automatic set_ramp();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) img[r][c] = 10 * c;
   endtask

   task automatic set_step();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) img[r][c] = (r < 2) ? 100 : 0;
   endtask

   task automatic set_random();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) img[r][c] = int'($urandom_range(0, PMAX));
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int start;
      repeat (3) @(negedge clk);
      tb_check("rst_out_valid", int'(out_valid), 0);
      tb_check("rst_busy", int'(busy), 0);
      tb_check("rst_in_ready", int'(in_ready), 1);
      tb_check("rst_out_pixel", int'(out_pixel), 0);
      tb_check("rst_flags", int'({out_sof, out_eol, out_eof}), 0);
      rst_n = 1'b1;
      @(posedge clk);

      set_ramp();
      run_frame(0, 0, 1'b0, 1'b0);
      run_frame(3, 80, 1'b0, 1'b0);
      run_frame(3, 81, 1'b0, 1'b0);
      run_frame(0, 0, 1'b1, 1'b0);

      set_step();
      run_frame(0, 0, 1'b0, 1'b0);
      run_frame(1, 0, 1'b0, 1'b0);
      run_frame(2, 0, 1'b0, 1'b0);
      run_frame(1, 0, 1'b1, 1'b1);

      set_random();
      run_frame(1, 0, 1'b0, 1'b0);
      run_frame(1, 0, 1'b1, 1'b0);
      run_frame(0, 0, 1'b1, 1'b0);
      run_frame(2, 0, 1'b1, 1'b0);
      run_frame(3, 300, 1'b1, 1'b1);

      // Aborted frame: six pixels produce only output (0,0) before the new SOF.
      set_ramp();
      mode  = 2'd0;
      start = n_out;
      exp_q.push_back(golden(0, 0, 0));
      for (int n = 0; n < 6; n++) send_pixel(img[n / COLS][n % COLS], n == 0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      repeat (2) @(negedge clk);
      tb_check("abort_prefix_outputs", n_out - start, 1);
      tb_check("abort_busy", int'(busy), 1);
      run_frame(0, 0, 1'b0, 1'b0);

      // Reset mid-frame discards it; later non-SOF pixels are ignored.
      start = n_out;
      for (int n = 0; n < 4; n++) send_pixel(img[n / COLS][n % COLS], n == 0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      tb_check("midrst_busy", int'(busy), 0);
      tb_check("midrst_in_ready", int'(in_ready), 1);
      rst_n = 1'b1;
      for (int n = 0; n < 8; n++) send_pixel(n * 7, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      tb_check("midrst_no_outputs", n_out - start, 0);
      tb_check("midrst_idle", int'(busy), 0);
      run_frame(0, 0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
